// File: rtl/psram_qpi_ctrl_if.sv
// Requester-side bus of the PSRAM controller: one 32-bit word per request.
interface psram_qpi_ctrl_if;
    logic        req;
    logic        we;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;

    // The requester drives the request and write data; it observes status and read data.
    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  ack,
        input  rdata
    );

    // The controller consumes the request and returns status and read data.
    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output ack,
        output rdata
    );
endinterface

// File: rtl/psram_qpi_ctrl.sv
// QSPI PSRAM sequencer: powers up the device, switches it to QPI with 0x35,
// then runs one full-word quad read (0xEB) or quad write (0x38) per request.
// SCLK runs at clk/2: phase L (sclk=0) presents data, phase H (sclk=1) lets the
// device sample; read data is captured on the edge that ends phase H.
// The SIO tristate buffers live in the top level.
module psram_qpi_ctrl #(
    parameter int POWERUP_CYCLES = 4050,
    parameter int WAIT_CYCLES    = 6,
    parameter int CE_GAP         = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    psram_qpi_ctrl_if.slave        bus_if,
    output logic                   psram_ce_n_o,
    output logic                   psram_sclk_o,
    output logic [3:0]             sio_o,
    output logic                   sio_oe_o,
    input  logic [3:0]             sio_i
);
    localparam int          CNT_W      = 16;
    // Init command sent serially on SIO0 while the device is still in SPI mode.
    localparam logic [63:0] INIT_FRAME = {8'h35, 56'd0};

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_CMD,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DONE,
        S_GAP,
        S_IDLE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;      // power-up count, remaining SCLK periods, or gap cycles
    logic [63:0]        tx_q;       // outgoing bits, next one at the top
    logic [31:0]        rx_q;       // read nibbles collected during DATA
    logic               we_q;
    logic [31:0]        rdata_q;
    logic               ce_n_q;
    logic               sclk_q;
    logic [3:0]         sio_o_q;
    logic               sio_oe_q;
    logic               ready_q;
    logic               ack_q;

    logic [63:0]        frame_d;
    logic               addr_unused;

    // Full QPI frame for the incoming request: command, 24-bit word address, write data.
    always_comb begin
        frame_d = {(bus_if.we ? 8'h38 : 8'hEB), 1'b0, bus_if.addr[22:2], 2'b00, bus_if.wdata};
    end

    // Byte-offset bits are not transmitted; the device is always word-addressed here.
    assign addr_unused = ^bus_if.addr[1:0];

    // Controller FSM with all pin and bus outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT_WAIT;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            ce_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sio_o_q  <= 4'h0;
            sio_oe_q <= 1'b0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_INIT_WAIT: begin
                    if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                        state_q  <= S_INIT_CMD;
                        cnt_q    <= CNT_W'(8);
                        ce_n_q   <= 1'b0;
                        sio_oe_q <= 1'b1;
                        sio_o_q  <= {3'b000, INIT_FRAME[63]};
                        tx_q     <= {INIT_FRAME[62:0], 1'b0};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_INIT_CMD, S_CMD, S_ADDR, S_WAIT, S_DATA: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        // End of phase H: the device has sampled, and read data is stable.
                        sclk_q <= 1'b0;
                        if (state_q == S_DATA && !we_q) begin
                            rx_q <= {rx_q[27:0], sio_i};
                        end
                        if (cnt_q != CNT_W'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                            if (state_q == S_INIT_CMD) begin
                                sio_o_q <= {3'b000, tx_q[63]};
                                tx_q    <= {tx_q[62:0], 1'b0};
                            end else if (sio_oe_q) begin
                                sio_o_q <= tx_q[63:60];
                                tx_q    <= {tx_q[59:0], 4'h0};
                            end
                        end else begin
                            case (state_q)
                                S_INIT_CMD: begin
                                    state_q  <= S_GAP;
                                    cnt_q    <= CNT_W'(CE_GAP);
                                    ce_n_q   <= 1'b1;
                                    sio_oe_q <= 1'b0;
                                    sio_o_q  <= 4'h0;
                                end
                                S_CMD: begin
                                    state_q <= S_ADDR;
                                    cnt_q   <= CNT_W'(6);
                                    sio_o_q <= tx_q[63:60];
                                    tx_q    <= {tx_q[59:0], 4'h0};
                                end
                                S_ADDR: begin
                                    if (we_q) begin
                                        state_q <= S_DATA;
                                        cnt_q   <= CNT_W'(8);
                                        sio_o_q <= tx_q[63:60];
                                        tx_q    <= {tx_q[59:0], 4'h0};
                                    end else begin
                                        // Release the bus before the device starts driving it.
                                        state_q  <= (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
                                        cnt_q    <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES) : CNT_W'(8);
                                        sio_oe_q <= 1'b0;
                                        sio_o_q  <= 4'h0;
                                    end
                                end
                                S_WAIT: begin
                                    state_q <= S_DATA;
                                    cnt_q   <= CNT_W'(8);
                                end
                                default: begin
                                    // Last data period done: close the transaction.
                                    state_q  <= S_DONE;
                                    ce_n_q   <= 1'b1;
                                    sio_oe_q <= 1'b0;
                                    sio_o_q  <= 4'h0;
                                    ack_q    <= 1'b1;
                                    if (!we_q) begin
                                        rdata_q <= {rx_q[27:0], sio_i};
                                    end
                                end
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    // DONE already counts as the first CE# high cycle of the gap.
                    if (CE_GAP <= 1) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= S_GAP;
                        cnt_q   <= CNT_W'(CE_GAP - 1);
                    end
                end

                S_GAP: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_IDLE: begin
                    if (bus_if.req) begin
                        state_q  <= S_CMD;
                        cnt_q    <= CNT_W'(2);
                        we_q     <= bus_if.we;
                        ready_q  <= 1'b0;
                        ce_n_q   <= 1'b0;
                        sclk_q   <= 1'b0;
                        sio_oe_q <= 1'b1;
                        sio_o_q  <= frame_d[63:60];
                        tx_q     <= {frame_d[59:0], 4'h0};
                    end
                end

                default: begin
                    state_q  <= S_INIT_WAIT;
                    cnt_q    <= '0;
                    ce_n_q   <= 1'b1;
                    sclk_q   <= 1'b0;
                    sio_oe_q <= 1'b0;
                    sio_o_q  <= 4'h0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign psram_ce_n_o  = ce_n_q;
    assign psram_sclk_o  = sclk_q;
    assign sio_o         = sio_o_q;
    assign sio_oe_o      = sio_oe_q;
    assign bus_if.ready  = ready_q;
    assign bus_if.ack    = ack_q;
    assign bus_if.rdata  = rdata_q;
endmodule

// File: doc/psram_qpi_ctrl.md
Name: psram_qpi_ctrl

Overview:
- Sequences the on-board QSPI PSRAM (PSRAM_CEn / PSRAM_CLK / PSRAM_SIO[3:0] on the Tang Nano) for a single 32-bit word requester (CPU data bus or a future arbiter).
- After power-up, switches the device from SPI to QPI mode, then performs one full-word quad read (0xEB) or quad write (0x38) per request.
- The top level owns the SIO tristate buffers; this block drives out, output-enable and in.

Parameters:
POWERUP_CYCLES, 4050, clk cycles to hold CE# high after reset before init (150 us at 27 MHz)
WAIT_CYCLES, 6, PSRAM read wait (dummy) SCLK cycles after address
CE_GAP, 2, minimum clk cycles CE# stays high between transactions (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  1  transaction request, sampled when ready=1
we  in  1  1=write, 0=read; sampled with req
addr  in  23  byte address; bits [1:0] ignored, sent as 0
wdata  in  32  write word; sampled with req
ready  out  1  1 = controller idle and initialised, req will be accepted
ack  out  1  one-cycle pulse: transaction complete; rdata valid in the same cycle for reads
rdata  out  32  read word; holds until the next read ack
psram_ce_n  out  1  chip enable, active low
psram_sclk  out  1  PSRAM serial clock
sio_o  out  4  SIO output data
sio_oe  out  1  1 = drive SIO
sio_i  in  4  SIO input data

Behaviour:
- Reset values (asynchronous): psram_ce_n=1, psram_sclk=0, sio_o=0, sio_oe=0, ready=0, ack=0, rdata=0, state=INIT_WAIT.
- SCLK runs at clk/2 and only while CE# is low. Each SCLK bit-period is 2 clk cycles:
  - Phase L: sclk=0, new sio_o driven.
  - Phase H: sclk=1; the device samples on the rising edge.
  - Input sampling: sio_i is captured at the end of phase H (on the clk edge that returns sclk to 0).
- INIT_WAIT: count POWERUP_CYCLES, then go to INIT_CMD.
- INIT_CMD: CE# low, sio_oe=1. Shift 0x35 MSB-first on sio_o[0] over 8 SCLK periods (16 clk); sio_o[3:1]=0. Then go to GAP, and from there to IDLE; ready=1 from then on.
- IDLE: ready=1. On req=1, latch we/addr/wdata, set ready=0, drop CE#, go to CMD.
  - req while ready=0 is ignored; the requester must hold it.
- CMD: 2 SCLK (4 clk). Command nibbles MSB-first: 0xEB (read) or 0x38 (write).
- ADDR: 6 SCLK (12 clk). Nibbles of {1'b0, addr[22:2], 2'b00}, MSB-first.
- WAIT (reads only): WAIT_CYCLES SCLK with sio_oe=0.
- DATA: 8 SCLK (16 clk), nibbles MSB-first.
  - Write: sio_oe=1, drive wdata[31:28] first.
  - Read: sio_oe=0, shift sio_i into rdata[3:0] with left shift, so the first nibble ends in rdata[31:28].
- DONE: CE# high, sclk=0, sio_oe=0, ack=1 for exactly this cycle. Go to GAP.
- GAP: CE# high for CE_GAP cycles total, counting DONE as the first; then IDLE.
- Latency, with req accepted in cycle 0:
  - Write: ack in cycle 33.
  - Read (WAIT_CYCLES=6): ack in cycle 45.
  - Next accept no earlier than cycle ack+CE_GAP.
- Address: bit 23 is always 0; wraps within 8 MB; no alignment error is reported.
- Reset asserted mid-transaction: outputs return to reset values immediately, CE# rises, and full init (INIT_WAIT then 0x35) is redone. No ack for the aborted transaction.
- sio_oe is never 1 during WAIT, read DATA, or while CE# is high.

Test Plan:
- Init: release rst with POWERUP_CYCLES=10 -> CE# high for 10 cycles, then CE# low with sio_o[0] serial 0,0,1,1,0,1,0,1 over 8 sclk rising edges; ready=1 after CE_GAP.
- Write: req, we=1, addr=0x123456, wdata=0xDEADBEEF -> nibbles on sclk rising edges: 3,8,1,2,3,4,5,4,D,E,A,D,B,E,E,F; ack in cycle 33; CE# high in cycle 33.
- Read: PSRAM model returns 0xCAFEF00D at addr 0x000010 -> nibbles E,B,0,0,0,0,1,0, then 6 sclk with sio_oe=0, then 8 data sclk; ack in cycle 45 with rdata=0xCAFEF00D.
- Back-to-back: req held high for write then read -> second CMD starts exactly CE_GAP cycles after the first ack; CE# high for >= CE_GAP cycles; both acks are single pulses.
- Early req: req=1 during INIT_WAIT/INIT_CMD -> no transaction starts; first command after init is the held request.
- Reset mid-read: assert rst during DATA -> CE#=1, sclk=0, sio_oe=0, ready=0 the same cycle; no ack; after release the 0x35 init repeats.
